// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war score keeper: FSM states,
// winner encodings and active-low {g,f,e,d,c,b,a} seven-segment patterns.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        POINT = 2'd1,
        HOLD  = 2'd2,
        OVER  = 2'd3
    } tug_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/tug_scorekeeper_score_hex.sv
// Score-to-digit decoder: maps an SW-bit score to an active-low seven-segment
// pattern; values above 9 show blank.
module score_hex
    import tug_pkg::*;
#(
    parameter int SW = 3
) (
    input  logic [SW-1:0] score,
    output logic [6:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (int'(score) == i) seg = SEG_DIGIT[i];
        end
    end

endmodule

// File: rtl/tug_scorekeeper.sv
// Point/match controller downstream of the tug-of-war light bar. The score
// digits are decoded only when TUG_SCORE_HEX_EN is defined; otherwise blank.
module tug_scorekeeper
    import tug_pkg::*;
#(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SW          = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          L,
    input  logic          R,
    input  logic          edge_l,
    input  logic          edge_r,
    output logic          point_rst,
    output logic [SW-1:0] score_l,
    output logic [SW-1:0] score_r,
    output logic [1:0]    winner,
    output logic          match_over,
    output logic [6:0]    hex_l,
    output logic [6:0]    hex_r
);

    localparam int          HW        = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [SW-1:0] MAX_S     = SW'(MAX_SCORE);

    tug_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [SW-1:0] score_l_q, score_l_d;
    logic [SW-1:0] score_r_q, score_r_d;
    logic [1:0]    winner_q, winner_d;
    logic          last_l_q, last_l_d;

    // A simultaneous press never moves the bar, so it never scores either.
    logic pt_l, pt_r;
    assign pt_l = edge_l & L & ~R;
    assign pt_r = edge_r & R & ~L;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            hold_cnt_q <= '0;
            score_l_q  <= '0;
            score_r_q  <= '0;
            winner_q   <= WIN_NONE;
            last_l_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            last_l_q   <= last_l_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        winner_d   = winner_q;
        last_l_d   = last_l_q;
        case (state_q)
            PLAY: begin
                if (pt_l) begin
                    score_l_d = (score_l_q >= MAX_S) ? MAX_S : score_l_q + SW'(1);
                    last_l_d  = 1'b1;
                    state_d   = POINT;
                end else if (pt_r) begin
                    score_r_d = (score_r_q >= MAX_S) ? MAX_S : score_r_q + SW'(1);
                    last_l_d  = 1'b0;
                    state_d   = POINT;
                end
            end
            POINT: begin
                if (last_l_q ? (score_l_q == MAX_S) : (score_r_q == MAX_S)) begin
                    winner_d = last_l_q ? WIN_L : WIN_R;
                    state_d  = OVER;
                end else if (HOLD_CYCLES == 0) begin
                    state_d = PLAY;
                end else begin
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q <= HW'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = PLAY;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: ;  // OVER: only reset leaves
        endcase
    end

    // OVER keeps the bar pinned at centre until the next match.
    assign point_rst  = (state_q == POINT) || (state_q == OVER);
    assign match_over = (state_q == OVER);
    assign winner     = winner_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;

`ifdef TUG_SCORE_HEX_EN
    score_hex #(.SW(SW)) u_hex_l (.score(score_l_q), .seg(hex_l));
    score_hex #(.SW(SW)) u_hex_r (.score(score_r_q), .seg(hex_r));
`else
    assign hex_l = SEG_BLANK;
    assign hex_r = SEG_BLANK;
`endif

endmodule
